// File: rtl/mod_check_scheduler_if.sv
// rtl/mod_check_scheduler_if.sv - request/response bundle for the shared remainder engine
interface mod_check_scheduler_if #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3
);
    localparam int LENW = $clog2(WIDTH + 1);
    localparam int IDW  = $clog2(NREQ);
    localparam int REMW = $clog2(DIVISOR);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*LENW-1:0]  req_len;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_div;
    logic [REMW-1:0]       rsp_rem;

    modport master (
        output req_valid, req_data, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_div, rsp_rem
    );

    modport slave (
        input  req_valid, req_data, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_div, rsp_rem
    );
endinterface

// File: rtl/mod_check_scheduler.sv
// rtl/mod_check_scheduler.sv - round-robin shared serial mod-DIVISOR engine
module mod_check_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    mod_check_scheduler_if.slave       bus,
    output logic                       busy
);
    localparam int LENW = $clog2(WIDTH + 1);
    localparam int IDW  = $clog2(NREQ);
    localparam int REMW = $clog2(DIVISOR);

    localparam logic [IDW:0]    NREQ_C  = (IDW+1)'(NREQ);
    localparam logic [LENW-1:0] WIDTH_C = LENW'(WIDTH);
    localparam logic [REMW:0]   DIV_C   = (REMW+1)'(DIVISOR);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [REMW-1:0]   rem_q, rem_d;
    logic [REMW-1:0]   rsp_rem_q, rsp_rem_d;
    logic              rsp_div_q, rsp_div_d;

    logic [2*NREQ-1:0] rot;
    logic [IDW:0]      off;
    logic [IDW:0]      sum;
    logic              gnt_found;
    logic [IDW-1:0]    gnt_idx;
    logic [WIDTH-1:0]  sel_data;
    logic [LENW-1:0]   sel_len;
    logic [LENW-1:0]   len_eff;
    logic [REMW:0]     t;
    logic [REMW-1:0]   rem_step;

    // Rotate so the rr pointer sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        rot       = {bus.req_valid, bus.req_valid} >> rr_q;
        gnt_found = 1'b0;
        off       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_found = 1'b1;
                off       = (IDW+1)'(k);
            end
        end
        sum     = {1'b0, rr_q} + off;
        gnt_idx = (sum >= NREQ_C) ? IDW'(sum - NREQ_C) : IDW'(sum);
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
                sel_len  = bus.req_len[i*LENW +: LENW];
            end
        end
        len_eff = (sel_len > WIDTH_C) ? WIDTH_C : sel_len;
    end

    // t < 2*DIVISOR, so one conditional subtract keeps rem in range.
    always_comb begin
        t        = {rem_q, 1'b0} + {{REMW{1'b0}}, data_q[WIDTH-1]};
        rem_step = (t >= DIV_C) ? REMW'(t - DIV_C) : REMW'(t);
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && gnt_found && !reset) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_div   = rsp_div_q;
    assign bus.rsp_rem   = rsp_rem_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        rem_d     = rem_q;
        rsp_rem_d = rsp_rem_q;
        rsp_div_d = rsp_div_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    id_d  = gnt_idx;
                    rr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    rem_d = '0;
                    cnt_d = len_eff;
                    // Left-align the live bits so the engine always consumes the MSB.
                    data_d = sel_data << (WIDTH_C - len_eff);
                    if (len_eff == '0) begin
                        state_d   = RESP;
                        rsp_rem_d = '0;
                        rsp_div_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                rem_d  = rem_step;
                data_d = data_q << 1;
                cnt_d  = cnt_q - LENW'(1);
                if (cnt_q == LENW'(1)) begin
                    state_d   = RESP;
                    rsp_rem_d = rem_step;
                    rsp_div_d = (rem_step == '0);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            rem_q     <= '0;
            rsp_rem_q <= '0;
            rsp_div_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            rsp_rem_q <= rsp_rem_d;
            rsp_div_q <= rsp_div_d;
        end
    end
endmodule

// File: tb/tb_mod_check_scheduler.sv
// tb/tb_mod_check_scheduler.sv - scoreboard bench for mod_check_scheduler
module tb_mod_check_scheduler;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int DIVISOR = 3;
    localparam int LENW    = $clog2(WIDTH + 1);
    localparam int IDW     = $clog2(NREQ);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    mod_check_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(DIVISOR)) bus ();

    mod_check_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int rem;
        int len;
        int t;
    } exp_t;

    exp_t sbq[$];
    int   gnt_log[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mrr = 0;
    int   last_rem = -1;
    int   last_lat = -1;
    logic [NREQ-1:0] acc_vec = '0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (v[idx[IDW-1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic int ref_rem(input logic [WIDTH-1:0] d, input int len);
        int     l;
        longint v;
        l = (len > WIDTH) ? WIDTH : len;
        v = 0;
        for (int b = 0; b < l; b++) begin
            if (d[b]) v += (longint'(1) << b);
        end
        return int'(v % DIVISOR);
    endfunction

    always @(negedge clk) begin : mon
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] av;
        logic [NREQ*LENW-1:0] lenv;
        logic [NREQ*WIDTH-1:0] datv;
        exp_t e;
        av = '0;
        if (reset) begin
            sbq.delete();
            mrr     <= 0;
            prev_rv <= 1'b0;
        end else begin
            chk("busy", int'(busy), int'(sbq.size() != 0));
            if (sbq.size() == 0) begin
                g = pick(bus.req_valid, mrr);
                exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
                chk("req_ready_idle", int'(bus.req_ready), int'(exp_rdy));
                chk("rsp_valid_idle", int'(bus.rsp_valid), 0);
                if (g >= 0) begin
                    lenv  = bus.req_len >> (g * LENW);
                    datv  = bus.req_data >> (g * WIDTH);
                    e.id  = g;
                    e.len = int'(lenv[LENW-1:0]);
                    e.rem = ref_rem(datv[WIDTH-1:0], e.len);
                    e.t   = cyc;
                    sbq.push_back(e);
                    gnt_log.push_back(g);
                    mrr <= (g + 1) % NREQ;
                    av  = NREQ'(1) << g;
                end
            end else begin
                e = sbq[0];
                chk("req_ready_busy", int'(bus.req_ready), 0);
                if (bus.rsp_valid) begin
                    if (!prev_rv) begin
                        chk("latency", cyc - e.t, ((e.len > WIDTH) ? WIDTH : e.len) + 1);
                        last_lat <= cyc - e.t;
                    end
                    chk("rsp_id", int'(bus.rsp_id), e.id);
                    chk("rsp_rem", int'(bus.rsp_rem), e.rem);
                    chk("rsp_div", int'(bus.rsp_div), int'(e.rem == 0));
                    if (bus.rsp_ready) begin
                        last_rem <= int'(bus.rsp_rem);
                        void'(sbq.pop_front());
                    end
                end
            end
            prev_rv <= bus.rsp_valid;
        end
        acc_vec <= av;
    end

    task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] d,
                           input logic [LENW-1:0] l);
        logic [NREQ*WIDTH-1:0] dm;
        logic [NREQ*LENW-1:0]  lm;
        dm = (NREQ*WIDTH)'({WIDTH{1'b1}}) << (i * WIDTH);
        lm = (NREQ*LENW)'({LENW{1'b1}}) << (i * LENW);
        bus.req_data = (bus.req_data & ~dm) | ((NREQ*WIDTH)'(d) << (i * WIDTH));
        bus.req_len  = (bus.req_len & ~lm) | ((NREQ*LENW)'(l) << (i * LENW));
        bus.req_valid[i[IDW-1:0]] = v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
        chk({tag, "_rsp_div"}, int'(bus.rsp_div), 0);
        chk({tag, "_rsp_rem"}, int'(bus.rsp_rem), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Retire accepted requests (scrambling their data afterwards) until none is pending.
    task automatic drain_reqs();
        int c;
        c = 0;
        while (bus.req_valid != '0 && c < 300) begin
            @(posedge clk); #1;
            c++;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_vec[i[IDW-1:0]]) set_req(i, 1'b0, WIDTH'($urandom), LENW'($urandom_range(0, 15)));
            end
        end
        chk("grant_timeout", int'(bus.req_valid != '0), 0);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((sbq.size() != 0 || bus.rsp_valid) && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        chk("idle_timeout", int'(c >= 300), 0);
    endtask

    task automatic plan(input int i, input logic [WIDTH-1:0] d, input int len,
                        input int exp_rem, input int exp_lat);
        set_req(i, 1'b1, d, LENW'(len));
        drain_reqs();
        wait_idle();
        chk("plan_rem", last_rem, exp_rem);
        chk("plan_lat", last_lat, exp_lat);
    endtask

    task automatic chk_order(input string name, input int a, input int b);
        chk({name, "_count"}, gnt_log.size(), 2 + int'(a < 0) * 2);
        if (a < 0) begin
            for (int k = 0; k < gnt_log.size(); k++) chk(name, gnt_log[k], k);
        end else begin
            if (gnt_log.size() > 0) chk(name, gnt_log[0], a);
            if (gnt_log.size() > 1) chk(name, gnt_log[1], b);
        end
    endtask

    initial begin
        int c;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, WIDTH'($urandom), LENW'($urandom_range(0, 12)));
        #2;
        chk_zero("reset_init");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        gnt_log.delete();
        drain_reqs();
        wait_idle();
        chk_order("rr_all", -1, -1);

        gnt_log.delete();
        set_req(1, 1'b1, 8'h3C, 4'd6);
        set_req(3, 1'b1, 8'h91, 4'd8);
        drain_reqs();
        wait_idle();
        chk_order("rr_1_3", 1, 3);

        plan(0, 8'd9,  8,  0, 9);
        plan(0, 8'd7,  3,  1, 4);
        plan(0, 8'hA5, 4,  2, 5);
        plan(0, 8'hFF, 8,  0, 9);
        plan(1, 8'h5A, 0,  0, 1);
        plan(2, 8'd10, 12, 1, 9);

        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 8'hC3, 4'd8);
        c = 0;
        while (!bus.rsp_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
            if (acc_vec[0]) begin
                set_req(0, 1'b0, 8'h00, 4'd0);
                set_req(3, 1'b1, 8'h2D, 4'd5);
            end
        end
        chk("bp_rsp_timeout", int'(bus.rsp_valid), 1);
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        drain_reqs();
        wait_idle();

        set_req(2, 1'b1, 8'hB7, 4'd8);
        c = 0;
        while (!acc_vec[2] && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        set_req(2, 1'b0, 8'h00, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        set_req(1, 1'b1, 8'h11, 4'd5);
        set_req(3, 1'b1, 8'h22, 4'd7);
        #1 reset = 1'b1;
        #1 chk_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        gnt_log.delete();
        drain_reqs();
        wait_idle();
        chk_order("rr_after_reset", 1, 3);

        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc_vec[i[IDW-1:0]] || $urandom_range(0, 7) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), WIDTH'($urandom), LENW'($urandom_range(0, 15)));
                end
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
